axis_pkt_framer: RTL and testbench



---
 rtl/axis_pkt_framer.sv | 147 ++++++++++++++
 tb/tb_axis_pkt_framer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_framer.sv
// Buffers one VIP2DUT_WORDS_NUM-word packet and forwards it one cycle after its tlast; input stalls while sending, output holds under any backpressure.
// Malformed packets are dropped and counted; define AXIS_PKT_FRAMER_PAD_EN to zero-pad short good packets instead of dropping them.
module axis_pkt_framer #(
   parameter int C_DATA_WIDTH      = 128,
   parameter int VIP2DUT_WORDS_NUM = 10,
   parameter int DROP_CNT_WIDTH    = 16
) (
   input  logic                        s_axis_aclk,
   input  logic                        s_axis_areset,
   input  logic                        s_axis_tvalid,
   output logic                        s_axis_tready,
   input  logic [C_DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [C_DATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic                        s_axis_tlast,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic [C_DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [C_DATA_WIDTH/8-1:0]   m_axis_tkeep,
   output logic                        m_axis_tlast,
   output logic                        pkt_dropped,
   output logic [DROP_CNT_WIDTH-1:0]   drop_cnt
);

   localparam int N  = VIP2DUT_WORDS_NUM;
   localparam int CW = $clog2(N);
   localparam int KW = C_DATA_WIDTH / 8;
   localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

   typedef enum logic [1:0] {S_FILL, S_DISCARD, S_SEND} state_t;

   state_t                    state_q;
   logic [CW-1:0]             wr_cnt_q, rd_cnt_q;
   logic [CW-1:0]             wr_cnt_inc, rd_cnt_inc;
   logic                      bad_q;
   logic                      s_rdy_q, m_vld_q, m_last_q, drop_q;
   logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;
   logic [C_DATA_WIDTH-1:0]   pkt_mem_q [N];

   logic fill_hs, bad_word, at_last, short_ok, drop_ev, fwd_ev;

   assign wr_cnt_inc = wr_cnt_q + CW'(1);
   assign rd_cnt_inc = rd_cnt_q + CW'(1);
   assign fill_hs    = (state_q == S_FILL) && s_axis_tvalid && s_rdy_q;
   assign bad_word   = bad_q || (s_axis_tkeep != {KW{1'b1}});
   assign at_last    = (wr_cnt_q == LAST_IDX);

`ifdef AXIS_PKT_FRAMER_PAD_EN
   localparam int FW = CW + 1;
   logic [FW-1:0] fill_len_q;
   assign short_ok     = !bad_word;
   assign m_axis_tdata = ({1'b0, rd_cnt_q} >= fill_len_q) ? '0 : pkt_mem_q[rd_cnt_q];
`else
   assign short_ok     = 1'b0;
   assign m_axis_tdata = pkt_mem_q[rd_cnt_q];
`endif

   // Long packets are dropped on their N-th word, before the trailing words are discarded.
   assign drop_ev = fill_hs && (at_last ? (!s_axis_tlast || bad_word) : (s_axis_tlast && !short_ok));
   assign fwd_ev  = fill_hs && s_axis_tlast && (at_last ? !bad_word : short_ok);

   always_ff @(posedge s_axis_aclk) begin
      if (fill_hs) begin
         pkt_mem_q[wr_cnt_q] <= s_axis_tdata;
      end
   end

   always_ff @(posedge s_axis_aclk) begin
      if (s_axis_areset) begin
         state_q    <= S_FILL;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         bad_q      <= 1'b0;
         s_rdy_q    <= 1'b1;
         m_vld_q    <= 1'b0;
         m_last_q   <= 1'b0;
         drop_q     <= 1'b0;
         drop_cnt_q <= '0;
`ifdef AXIS_PKT_FRAMER_PAD_EN
         fill_len_q <= '0;
`endif
      end else begin
         drop_q <= drop_ev;
         if (drop_ev && (drop_cnt_q != {DROP_CNT_WIDTH{1'b1}})) begin
            drop_cnt_q <= drop_cnt_q + DROP_CNT_WIDTH'(1);
         end
         case (state_q)
            S_FILL: begin
               if (fill_hs) begin
                  if (drop_ev || fwd_ev) begin
                     wr_cnt_q <= '0;
                     bad_q    <= 1'b0;
                  end else begin
                     wr_cnt_q <= wr_cnt_inc;
                     bad_q    <= bad_word;
                  end
                  if (fwd_ev) begin
                     state_q  <= S_SEND;
                     s_rdy_q  <= 1'b0;
                     m_vld_q  <= 1'b1;
                     m_last_q <= 1'b0;
                     rd_cnt_q <= '0;
`ifdef AXIS_PKT_FRAMER_PAD_EN
                     fill_len_q <= at_last ? FW'(N) : (FW'(wr_cnt_q) + FW'(1));
`endif
                  end else if (drop_ev && !s_axis_tlast) begin
                     state_q <= S_DISCARD;
                  end
               end
            end
            S_DISCARD: begin
               if (s_axis_tvalid && s_rdy_q && s_axis_tlast) begin
                  state_q <= S_FILL;
               end
            end
            S_SEND: begin
               if (m_axis_tready) begin
                  if (rd_cnt_q == LAST_IDX) begin
                     state_q  <= S_FILL;
                     s_rdy_q  <= 1'b1;
                     m_vld_q  <= 1'b0;
                     m_last_q <= 1'b0;
                     rd_cnt_q <= '0;
                     wr_cnt_q <= '0;
                     bad_q    <= 1'b0;
                  end else begin
                     rd_cnt_q <= rd_cnt_inc;
                     m_last_q <= (rd_cnt_inc == LAST_IDX);
                  end
               end
            end
            default: begin
               state_q <= S_FILL;
               s_rdy_q <= 1'b1;
               m_vld_q <= 1'b0;
            end
         endcase
      end
   end

   assign s_axis_tready = s_rdy_q;
   assign m_axis_tvalid = m_vld_q;
   assign m_axis_tlast  = m_last_q;
   assign m_axis_tkeep  = {KW{1'b1}};
   assign pkt_dropped   = drop_q;
   assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_axis_pkt_framer.sv
// Scoreboard bench for axis_pkt_framer with N=4, 128-bit data.
module tb_axis_pkt_framer;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic [127:0]  s_tdata = '0;
   logic [15:0]   s_tkeep = 16'hFFFF;
   logic          s_tlast = 1'b0;
   logic          m_tvalid;
   logic          m_tready = 1'b1;
   logic [127:0]  m_tdata;
   logic [15:0]   m_tkeep;
   logic          m_tlast;
   logic          pkt_dropped;
   logic [15:0]   drop_cnt;

   int compared = 0;
   int mismatched = 0;
   int drop_pulses = 0;
   int exp_drops = 0;
   int sink_mode = 0;
   int cyc = 0;
   logic [128:0] exp_q [$];

   logic         prev_stall = 1'b0;
   logic [127:0] prev_data = '0;
   logic         prev_last = 1'b0;

   localparam logic [127:0] PA = 128'hA0A0_0000_0000_0000_0000_0000_0000_0A00;
   localparam logic [127:0] PB = 128'hB1B1_0000_0000_0000_0000_0000_0000_0B00;
   localparam logic [127:0] PC = 128'hC2C2_0000_0000_0000_0000_0000_0000_0C00;
   localparam logic [127:0] PD = 128'hD3D3_0000_0000_0000_0000_0000_0000_0D00;
   localparam logic [127:0] PE = 128'hE4E4_0000_0000_0000_0000_0000_0000_0E00;
   localparam logic [127:0] PF = 128'hF5F5_0000_0000_0000_0000_0000_0000_0F00;

   axis_pkt_framer #(
      .C_DATA_WIDTH(128),
      .VIP2DUT_WORDS_NUM(4),
      .DROP_CNT_WIDTH(16)
   ) dut (
      .s_axis_aclk(clk),
      .s_axis_areset(rst),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready),
      .s_axis_tdata(s_tdata),
      .s_axis_tkeep(s_tkeep),
      .s_axis_tlast(s_tlast),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready),
      .m_axis_tdata(m_tdata),
      .m_axis_tkeep(m_tkeep),
      .m_axis_tlast(m_tlast),
      .pkt_dropped(pkt_dropped),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      compared++;
      mismatched++;
      $display("FAIL %s: timed out", name);
   endtask

   // Sink ready: always 1, or the repeating pattern 1,0,0.
   always @(posedge clk) begin
      #1;
      m_tready = (sink_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      cyc++;
   end

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (pkt_dropped) drop_pulses++;
         if (prev_stall) begin
            chk("hold_vld", 128'(m_tvalid), 128'd1);
            chk("hold_data", m_tdata, prev_data);
            chk("hold_last", 128'(m_tlast), 128'(prev_last));
         end
         if (m_tvalid) chk("in_stalled_in_send", 128'(s_tready), 128'd0);
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_out: got data %h last %0d, expected no output", m_tdata, m_tlast);
            end else begin
               logic [128:0] e;
               e = exp_q.pop_front();
               chk("out_data", m_tdata, e[127:0]);
               chk("out_last", 128'(m_tlast), 128'(e[128]));
               chk("out_keep", 128'(m_tkeep), 128'h FFFF);
            end
         end
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
         prev_last  = m_tlast;
      end
   end

   task automatic push_exp(input logic [127:0] d, input logic l);
      exp_q.push_back({l, d});
   endtask

   task automatic push_good(input logic [127:0] base);
      push_exp(base + 128'd0, 1'b0);
      push_exp(base + 128'd1, 1'b0);
      push_exp(base + 128'd2, 1'b0);
      push_exp(base + 128'd3, 1'b1);
   endtask

   // Called at posedge+1; returns at posedge+1 after the last word's handshake.
   task automatic send_pkt(input logic [127:0] base, input int n, input int bad_idx);
      for (int i = 0; i < n; i++) begin
         int t;
         s_tdata  = base + 128'(i);
         s_tkeep  = (i == bad_idx) ? 16'h00FF : 16'hFFFF;
         s_tlast  = (i == n - 1);
         s_tvalid = 1'b1;
         t = 0;
         while (!s_tready && t < 200) begin
            @(posedge clk); #1;
            t++;
         end
         if (t >= 200) fail_now("send_wait_ready");
         @(posedge clk); #1;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tkeep  = 16'hFFFF;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || m_tvalid) && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 300) fail_now("drain");
      repeat (3) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic chk_drops(input string name);
      chk({name, "_drop_cnt"}, 128'(drop_cnt), 128'(exp_drops));
      chk({name, "_drop_pulses"}, 128'(drop_pulses), 128'(exp_drops));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_s_tready", 128'(s_tready), 128'd1);
      chk("rst_m_tvalid", 128'(m_tvalid), 128'd0);
      chk("rst_m_tlast", 128'(m_tlast), 128'd0);
      chk("rst_pkt_dropped", 128'(pkt_dropped), 128'd0);
      chk("rst_drop_cnt", 128'(drop_cnt), 128'd0);
      chk("rst_m_tkeep", 128'(m_tkeep), 128'hFFFF);

      // 1: good packet, sink always ready
      push_good(PA);
      send_pkt(PA, 4, -1);
      chk("t1_latency_vld", 128'(m_tvalid), 128'd1);
      drain();
      chk("t1_s_tready", 128'(s_tready), 128'd1);
      chk_drops("t1");

      // 2: backpressure 1,0,0,...
      sink_mode = 1;
      push_good(PB);
      send_pkt(PB, 4, -1);
      drain();
      sink_mode = 0;
      chk("t2_s_tready", 128'(s_tready), 128'd1);
      chk_drops("t2");

      // 3: short packet
`ifdef AXIS_PKT_FRAMER_PAD_EN
      push_exp(PC + 128'd0, 1'b0);
      push_exp(PC + 128'd1, 1'b0);
      push_exp(128'd0, 1'b0);
      push_exp(128'd0, 1'b1);
      send_pkt(PC, 2, -1);
      chk("t3_pkt_dropped", 128'(pkt_dropped), 128'd0);
`else
      send_pkt(PC, 2, -1);
      exp_drops++;
      chk("t3_pkt_dropped", 128'(pkt_dropped), 128'd1);
`endif
      drain();
      chk_drops("t3");

      // 4: long packet then good packet
      send_pkt(PD, 6, -1);
      exp_drops++;
      drain();
      chk_drops("t4_long");
      push_good(PE);
      send_pkt(PE, 4, -1);
      drain();
      chk_drops("t4_good");

      // 5: bad keep on word 2
      send_pkt(PF, 4, 1);
      exp_drops++;
      chk("t5_pkt_dropped", 128'(pkt_dropped), 128'd1);
      drain();
      chk_drops("t5");

      // 6: reset after word B is delivered
      push_exp(PA + 128'd0, 1'b0);
      push_exp(PA + 128'd1, 1'b0);
      send_pkt(PA, 4, -1);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_drops = 0;
      drop_pulses = 0;
      chk("t6_m_tvalid", 128'(m_tvalid), 128'd0);
      chk("t6_s_tready", 128'(s_tready), 128'd1);
      chk("t6_m_tlast", 128'(m_tlast), 128'd0);
      chk("t6_exp_left", 128'(exp_q.size()), 128'd0);
      exp_q.delete();
      push_good(PB);
      send_pkt(PB, 4, -1);
      drain();
      chk_drops("t6");
      chk("final_queue_empty", 128'(exp_q.size()), 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
